// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - upstream/downstream handshake bundle for pipe_stage_reg
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 15,
    parameter int CNT_W  = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] q_data;
    logic [CTRL_W-1:0] q_ctrl;
    logic [CNT_W-1:0]  stall_cnt;

    modport slave (
        input  in_valid, in_data, in_ctrl, flush, out_ready,
        output in_ready, out_valid, q_data, q_ctrl, stall_cnt
    );

    modport master (
        output in_valid, in_data, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, q_data, q_ctrl, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - flushable pipeline stage register with stall counter; PIPE_SKID_EN adds a skid entry
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 15,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rn,
    pipe_stage_reg_if.slave      bus
);
    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CNT_W-1:0]  cnt;
    logic              ready;
    logic              in_xfer;
    logic              out_xfer;
    logic              stalled;

    assign in_xfer  = bus.in_valid && ready;
    assign out_xfer = main_valid && bus.out_ready;
    // A flush cycle never counts as stalled, so the count survives a kill.
    assign stalled  = main_valid && !bus.out_ready && !bus.flush;

`ifdef PIPE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    assign ready = !skid_valid && !bus.flush && rn;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_ctrl  <= '0;
        end else if (out_xfer || !main_valid) begin
            // Main slot frees up: the older skid entry goes first to keep order.
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_ctrl  <= skid_ctrl;
                skid_valid <= 1'b0;
                skid_ctrl  <= '0;
            end else if (in_xfer) begin
                main_valid <= 1'b1;
                main_data  <= bus.in_data;
                main_ctrl  <= bus.in_ctrl;
            end else begin
                main_valid <= 1'b0;
                main_ctrl  <= '0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
            skid_data  <= bus.in_data;
            skid_ctrl  <= bus.in_ctrl;
        end
    end
`else
    assign ready = (bus.out_ready || !main_valid) && !bus.flush && rn;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            main_valid <= 1'b0;
            main_data  <= '0;
            main_ctrl  <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end else if (in_xfer) begin
            main_valid <= 1'b1;
            main_data  <= bus.in_data;
            main_ctrl  <= bus.in_ctrl;
        end else if (out_xfer) begin
            main_valid <= 1'b0;
            main_ctrl  <= '0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            cnt <= '0;
        end else if (stalled && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = main_valid;
    assign bus.q_data    = main_data;
    assign bus.q_ctrl    = main_ctrl;
    assign bus.stall_cnt = cnt;
endmodule
